multi_timer: RTL and testbench

Parametrised multi-channel memory-mapped timer peripheral on the embedded SoC's shared peripheral bus. It provides NUM_CH independent counters, each with a compare value, an 8-bit prescaler, one-shot or periodic mode, and a sticky interrupt-pending flag. The block drives one maskable interrupt line per channel and an OR-combined line for the core.

---
 rtl/multi_timer.sv | 118 +++++++++++
 tb/tb_multi_timer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH memory-mapped compare timers with prescaler, one-shot/periodic mode and sticky IRQ.
// Zero-latency combinational reads, writes commit at the clk edge; the bus has no backpressure.
module multi_timer #(
  parameter int          NUM_CH = 4,
  parameter int          WIDTH  = 32,
  parameter logic [31:0] BASE   = 32'hffff0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  inout  wire  [31:0]       mem_data,
  output logic [NUM_CH-1:0] timer_int_vec,
  output logic              timer_int
);

  typedef struct packed {
    logic [7:0] presc;
    logic       mode;
    logic       ie;
    logic       en;
  } ctrl_t;

  logic [WIDTH-1:0]  cnt       [NUM_CH];
  logic [WIDTH-1:0]  cmp       [NUM_CH];
  ctrl_t             ctrl      [NUM_CH];
  logic [7:0]        presc_cnt [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] ie_vec;

  logic [3:0]  ch;
  logic [1:0]  rsel;
  logic        hit;
  logic [31:0] rdata;

  assign ch   = mem_addr[7:4];
  assign rsel = mem_addr[3:2];
  assign hit  = (mem_addr[31:8] == BASE[31:8]) &&
                ({1'b0, ch} < 5'(NUM_CH)) &&
                (mem_addr[1:0] == 2'b00);

  always_comb begin
    tick   = '0;
    match  = '0;
    wr_sel = '0;
    ie_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tick[i]   = ctrl[i].en && (presc_cnt[i] == ctrl[i].presc);
      match[i]  = tick[i] && (cnt[i] == cmp[i]);
      wr_sel[i] = mem_we && hit && (ch == 4'(i));
      ie_vec[i] = ctrl[i].ie;
    end
  end

  // Register writes take priority over the tick update; a match set of PENDING beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]       <= '0;
        cmp[i]       <= '0;
        ctrl[i]      <= '0;
        presc_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((wr_sel[i] && rsel == 2'd2) || !ctrl[i].en || tick[i])
          presc_cnt[i] <= '0;
        else
          presc_cnt[i] <= presc_cnt[i] + 8'd1;

        if (wr_sel[i] && rsel == 2'd0)
          cnt[i] <= mem_data[WIDTH-1:0];
        else if (match[i])
          cnt[i] <= '0;
        else if (tick[i])
          cnt[i] <= cnt[i] + 1'b1;

        if (wr_sel[i] && rsel == 2'd1)
          cmp[i] <= mem_data[WIDTH-1:0];

        if (wr_sel[i] && rsel == 2'd2)
          ctrl[i] <= ctrl_t'({mem_data[15:8], mem_data[2:0]});
        else if (match[i] && !ctrl[i].mode)
          ctrl[i].en <= 1'b0;

        if (match[i])
          pend[i] <= 1'b1;
        else if (wr_sel[i] && rsel == 2'd3 && mem_data[0])
          pend[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 4'(i)) begin
        case (rsel)
          2'd0:    rdata[WIDTH-1:0] = cnt[i];
          2'd1:    rdata[WIDTH-1:0] = cmp[i];
          2'd2:    rdata[15:0]      = {ctrl[i].presc, 5'b0, ctrl[i].mode, ctrl[i].ie, ctrl[i].en};
          default: rdata[0]         = pend[i];
        endcase
      end
    end
  end

  // Only a read hit drives the shared bus.
  assign mem_data = (!mem_we && hit) ? rdata : 'z;

  assign timer_int_vec = pend & ie_vec;
  assign timer_int     = |timer_int_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: three instances (4x32, 16x8, 1x8) share one pulled-up bus.
module tb_multi_timer;

  localparam logic [31:0] A = 32'hffff0100;
  localparam logic [31:0] B = 32'hffff0400;
  localparam logic [31:0] C = 32'hffff0500;
  localparam logic [31:0] FLOAT = 32'hffffffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  logic [31:0] drv_dat;
  logic        drv_en;

  logic [3:0]  vec_a;
  logic        int_a;
  logic [15:0] vec_b;
  logic        int_b;
  logic [0:0]  vec_c;
  logic        int_c;

  int checks = 0;
  int passed = 0;

  assign mem_data = drv_en ? drv_dat : 'z;
  pullup (mem_data);

  multi_timer #(.NUM_CH(4), .WIDTH(32), .BASE(A)) dut_a (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .timer_int_vec(vec_a), .timer_int(int_a));

  multi_timer #(.NUM_CH(16), .WIDTH(8), .BASE(B)) dut_b (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .timer_int_vec(vec_b), .timer_int(int_b));

  multi_timer #(.NUM_CH(1), .WIDTH(8), .BASE(C)) dut_c (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .timer_int_vec(vec_c), .timer_int(int_c));

  always #50 clk = ~clk;

  // Called in the low clock phase; commits at the next posedge and returns just after the following negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a; mem_we = 1'b1; drv_dat = d; drv_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_we = 1'b0; drv_en = 1'b0; mem_addr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a; mem_we = 1'b0; drv_en = 1'b0;
    #1;
    d = mem_data;
    mem_addr = 32'h0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst = 1'b1; mem_we = 1'b0; mem_addr = 32'h0; drv_en = 1'b0; drv_dat = 32'h0;
    cyc(3);
    checks++; if (int_a !== 1'b0) $display("FAIL reset_int_a got %b expected 0", int_a); else passed++;
    checks++; if (vec_a !== 4'b0) $display("FAIL reset_vec_a got %b expected 0000", vec_a); else passed++;
    checks++; if ({int_b, int_c} !== 2'b00) $display("FAIL reset_int_bc got %b expected 00", {int_b, int_c}); else passed++;
    rd(A + 32'h00, r); checks++; if (r !== 32'h0) $display("FAIL reset_count got %h expected 0", r); else passed++;
    rd(A + 32'h04, r); checks++; if (r !== 32'h0) $display("FAIL reset_cmp got %h expected 0", r); else passed++;
    rd(A + 32'h08, r); checks++; if (r !== 32'h0) $display("FAIL reset_ctrl got %h expected 0", r); else passed++;
    rd(A + 32'h0c, r); checks++; if (r !== 32'h0) $display("FAIL reset_status got %h expected 0", r); else passed++;
    rd(A + 32'h100, r); checks++; if (r !== FLOAT) $display("FAIL unmapped_read got %h expected %h", r, FLOAT); else passed++;
    rd(A + 32'h40, r); checks++; if (r !== FLOAT) $display("FAIL ch_out_of_range got %h expected %h", r, FLOAT); else passed++;
    rd(A + 32'h01, r); checks++; if (r !== FLOAT) $display("FAIL misaligned_read got %h expected %h", r, FLOAT); else passed++;
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_oneshot;
    logic [31:0] r;
    wr(A + 32'h04, 32'd3);
    wr(A + 32'h08, 32'h3);
    cyc(2);
    rd(A + 32'h00, r); checks++; if (r !== 32'd2) $display("FAIL oneshot_count_mid got %0d expected 2", r); else passed++;
    cyc(1);
    checks++; if (int_a !== 1'b0) $display("FAIL oneshot_early_int got %b expected 0", int_a); else passed++;
    cyc(1);
    checks++; if (int_a !== 1'b1) $display("FAIL oneshot_int got %b expected 1", int_a); else passed++;
    checks++; if (vec_a !== 4'b0001) $display("FAIL oneshot_vec got %b expected 0001", vec_a); else passed++;
    rd(A + 32'h0c, r); checks++; if (r !== 32'h1) $display("FAIL oneshot_pending got %h expected 1", r); else passed++;
    rd(A + 32'h08, r); checks++; if (r !== 32'h2) $display("FAIL oneshot_en_clear got %h expected 2", r); else passed++;
    cyc(3);
    rd(A + 32'h00, r); checks++; if (r !== 32'h0) $display("FAIL oneshot_count_hold got %h expected 0", r); else passed++;
    wr(A + 32'h0c, 32'h0);
    rd(A + 32'h0c, r); checks++; if (r !== 32'h1) $display("FAIL status_write0 got %h expected 1", r); else passed++;
    wr(A + 32'h0c, 32'h1);
    checks++; if (int_a !== 1'b0) $display("FAIL oneshot_int_clear got %b expected 0", int_a); else passed++;
    rd(A + 32'h0c, r); checks++; if (r !== 32'h0) $display("FAIL oneshot_status_clear got %h expected 0", r); else passed++;
  endtask

  task automatic test_periodic;
    logic [31:0] r;
    wr(A + 32'h14, 32'd4);
    wr(A + 32'h18, 32'h0207);
    cyc(14);
    rd(A + 32'h1c, r); checks++; if (r !== 32'h0) $display("FAIL periodic_early got %h expected 0", r); else passed++;
    cyc(1);
    rd(A + 32'h1c, r); checks++; if (r !== 32'h1) $display("FAIL periodic_first got %h expected 1", r); else passed++;
    checks++; if (vec_a !== 4'b0010) $display("FAIL periodic_vec got %b expected 0010", vec_a); else passed++;
    wr(A + 32'h1c, 32'h1);
    checks++; if (int_a !== 1'b0) $display("FAIL periodic_clear got %b expected 0", int_a); else passed++;
    cyc(13);
    rd(A + 32'h1c, r); checks++; if (r !== 32'h0) $display("FAIL periodic_second_early got %h expected 0", r); else passed++;
    cyc(1);
    rd(A + 32'h1c, r); checks++; if (r !== 32'h1) $display("FAIL periodic_second got %h expected 1", r); else passed++;
    checks++; if (int_a !== 1'b1) $display("FAIL periodic_int got %b expected 1", int_a); else passed++;
    rd(A + 32'h18, r); checks++; if (r !== 32'h0207) $display("FAIL periodic_en_kept got %h expected 0207", r); else passed++;
    wr(A + 32'h18, 32'h0);
    wr(A + 32'h1c, 32'h1);
  endtask

  task automatic test_wrap;
    logic [31:0] r;
    wr(B + 32'hf0, 32'h1234);
    rd(B + 32'hf0, r); checks++; if (r !== 32'h34) $display("FAIL count_trunc got %h expected 34", r); else passed++;
    wr(B + 32'hf4, 32'habcd);
    rd(B + 32'hf4, r); checks++; if (r !== 32'hcd) $display("FAIL cmp_trunc got %h expected cd", r); else passed++;
    wr(B + 32'hf8, 32'hffffffff);
    rd(B + 32'hf8, r); checks++; if (r !== 32'h0000ff07) $display("FAIL ctrl_mask got %h expected 0000ff07", r); else passed++;
    wr(B + 32'hf8, 32'h0);
    wr(B + 32'hf0, 32'd200);
    wr(B + 32'hf4, 32'd5);
    wr(B + 32'hf8, 32'h3);
    cyc(61);
    rd(B + 32'hfc, r); checks++; if (r !== 32'h0) $display("FAIL wrap_early got %h expected 0", r); else passed++;
    checks++; if (int_b !== 1'b0) $display("FAIL wrap_early_int got %b expected 0", int_b); else passed++;
    cyc(1);
    rd(B + 32'hfc, r); checks++; if (r !== 32'h1) $display("FAIL wrap_match got %h expected 1", r); else passed++;
    checks++; if (vec_b !== 16'h8000) $display("FAIL wrap_vec got %h expected 8000", vec_b); else passed++;
    rd(B + 32'hf0, r); checks++; if (r !== 32'h0) $display("FAIL wrap_count got %h expected 0", r); else passed++;
    wr(B + 32'hfc, 32'h1);
    checks++; if (int_b !== 1'b0) $display("FAIL wrap_clear got %b expected 0", int_b); else passed++;
  endtask

  task automatic test_params;
    logic [31:0] r;
    rd(C + 32'h10, r); checks++; if (r !== FLOAT) $display("FAIL single_ch_range got %h expected %h", r, FLOAT); else passed++;
    wr(C + 32'h04, 32'h0);
    wr(C + 32'h08, 32'h3);
    cyc(1);
    checks++; if (vec_c !== 1'b1) $display("FAIL single_ch_vec got %b expected 1", vec_c); else passed++;
    rd(C + 32'h08, r); checks++; if (r !== 32'h2) $display("FAIL single_ch_ctrl got %h expected 2", r); else passed++;
    wr(C + 32'h0c, 32'h1);
    checks++; if (int_c !== 1'b0) $display("FAIL single_ch_clear got %b expected 0", int_c); else passed++;
  endtask

  task automatic test_collision;
    logic [31:0] r;
    wr(A + 32'h04, 32'd2);
    wr(A + 32'h08, 32'h1);
    cyc(2);
    rd(A + 32'h0c, r); checks++; if (r !== 32'h0) $display("FAIL coll_pre got %h expected 0", r); else passed++;
    wr(A + 32'h0c, 32'h1);
    rd(A + 32'h0c, r); checks++; if (r !== 32'h1) $display("FAIL coll_set_beats_clear got %h expected 1", r); else passed++;
    wr(A + 32'h0c, 32'h1);

    wr(A + 32'h04, 32'd100);
    wr(A + 32'h08, 32'h1);
    cyc(3);
    rd(A + 32'h00, r); checks++; if (r !== 32'd3) $display("FAIL coll_count_pre got %0d expected 3", r); else passed++;
    wr(A + 32'h00, 32'd50);
    rd(A + 32'h00, r); checks++; if (r !== 32'd50) $display("FAIL coll_count_write got %0d expected 50", r); else passed++;
    wr(A + 32'h04, 32'd50);
    rd(A + 32'h00, r); checks++; if (r !== 32'd51) $display("FAIL coll_old_cmp got %0d expected 51", r); else passed++;
    rd(A + 32'h0c, r); checks++; if (r !== 32'h0) $display("FAIL coll_old_cmp_pend got %h expected 0", r); else passed++;
    wr(A + 32'h04, 32'd52);
    cyc(1);
    rd(A + 32'h0c, r); checks++; if (r !== 32'h1) $display("FAIL coll_new_cmp got %h expected 1", r); else passed++;
    rd(A + 32'h00, r); checks++; if (r !== 32'h0) $display("FAIL coll_new_cmp_count got %h expected 0", r); else passed++;
    wr(A + 32'h0c, 32'h1);

    wr(A + 32'h04, 32'd0);
    wr(A + 32'h08, 32'h1);
    wr(A + 32'h08, 32'h1);
    rd(A + 32'h08, r); checks++; if (r !== 32'h1) $display("FAIL coll_ctrl_beats_clear got %h expected 1", r); else passed++;
    rd(A + 32'h0c, r); checks++; if (r !== 32'h1) $display("FAIL coll_ctrl_pend got %h expected 1", r); else passed++;
    cyc(1);
    rd(A + 32'h08, r); checks++; if (r !== 32'h0) $display("FAIL coll_en_clear_after got %h expected 0", r); else passed++;
    wr(A + 32'h0c, 32'h1);
  endtask

  task automatic test_independence;
    logic [31:0] r;
    wr(A + 32'h34, 32'd1000);
    wr(A + 32'h24, 32'd1);
    wr(A + 32'h38, 32'h1);
    wr(A + 32'h28, 32'h1);
    cyc(1);
    rd(A + 32'h2c, r); checks++; if (r !== 32'h0) $display("FAIL indep_early got %h expected 0", r); else passed++;
    cyc(1);
    rd(A + 32'h2c, r); checks++; if (r !== 32'h1) $display("FAIL indep_masked_pend got %h expected 1", r); else passed++;
    checks++; if (vec_a !== 4'b0000) $display("FAIL indep_masked_vec got %b expected 0000", vec_a); else passed++;
    checks++; if (int_a !== 1'b0) $display("FAIL indep_masked_int got %b expected 0", int_a); else passed++;
    wr(A + 32'h28, 32'h2);
    checks++; if (vec_a !== 4'b0100) $display("FAIL indep_unmask_vec got %b expected 0100", vec_a); else passed++;
    checks++; if (int_a !== 1'b1) $display("FAIL indep_unmask_int got %b expected 1", int_a); else passed++;
    rd(A + 32'h30, r); checks++; if (r !== 32'd4) $display("FAIL indep_ch3_count got %0d expected 4", r); else passed++;
    rd(A + 32'h38, r); checks++; if (r !== 32'h1) $display("FAIL indep_ch3_ctrl got %h expected 1", r); else passed++;
    wr(A + 32'h2c, 32'h1);
    checks++; if (int_a !== 1'b0) $display("FAIL indep_clear got %b expected 0", int_a); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    wr(A + 32'h04, 32'd0);
    wr(A + 32'h08, 32'h7);
    cyc(1);
    checks++; if (int_a !== 1'b1) $display("FAIL midrst_pre_int got %b expected 1", int_a); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (int_a !== 1'b0) $display("FAIL midrst_async_int got %b expected 0", int_a); else passed++;
    checks++; if (vec_a !== 4'b0) $display("FAIL midrst_async_vec got %b expected 0000", vec_a); else passed++;
    rd(A + 32'h30, r); checks++; if (r !== 32'h0) $display("FAIL midrst_ch3_count got %h expected 0", r); else passed++;
    rd(A + 32'h38, r); checks++; if (r !== 32'h0) $display("FAIL midrst_ch3_ctrl got %h expected 0", r); else passed++;
    rd(A + 32'h08, r); checks++; if (r !== 32'h0) $display("FAIL midrst_ch0_ctrl got %h expected 0", r); else passed++;
    rd(A + 32'h0c, r); checks++; if (r !== 32'h0) $display("FAIL midrst_ch0_status got %h expected 0", r); else passed++;
    rd(A + 32'h100, r); checks++; if (r !== FLOAT) $display("FAIL midrst_unmapped got %h expected %h", r, FLOAT); else passed++;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    rd(A + 32'h30, r); checks++; if (r !== 32'h0) $display("FAIL postrst_count got %h expected 0", r); else passed++;
    checks++; if (int_a !== 1'b0) $display("FAIL postrst_int got %b expected 0", int_a); else passed++;
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_periodic;
    test_wrap;
    test_params;
    test_collision;
    test_independence;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
